// File: rtl/reg_dump.sv
// Sequential read-out of the register file: walks an inclusive, wrapping
// address range and streams each word, tagged with its address, over valid/ready.
module reg_dump #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last
);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] end_addr;

    // raddr doubles as the current-address pointer, so it only moves on LOAD entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            end_addr  <= '0;
            raddr     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        raddr    <= first_addr;
                        end_addr <= last_addr;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    out_data  <= rdata;
                    out_addr  <= raddr;
                    out_last  <= (raddr == end_addr);
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            raddr <= raddr + ADDR_WIDTH'(1);
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/reg_dump.md
# reg_dump

Sequential read-out engine on the read side of the 32 x 32-bit register file. On a start pulse it walks an inclusive address range and drives each address onto one register-file read port. It captures the returned word and presents it, tagged with its address, on a valid/ready stream toward the debug/trace path. It is a read-only initiator: it never drives the register file's write port.

## Interface
- DATA_WIDTH, 32, register width
- ADDR_WIDTH, 5, register address width (32 entries)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- first_addr  in  ADDR_WIDTH  first register to dump; latched on accepted start
- last_addr  in  ADDR_WIDTH  last register to dump, inclusive; latched on accepted start
- busy  out  1  high from the cycle after an accepted start until DONE exits
- done  out  1  one-cycle pulse after the final beat's handshake
- raddr  out  ADDR_WIDTH  to register-file read port; registered
- rdata  in  DATA_WIDTH  combinational read data from register file (reg 0 reads 0)
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready from consumer
- out_data  out  DATA_WIDTH  captured register value
- out_addr  out  ADDR_WIDTH  address of out_data
- out_last  out  1  high on the final beat of a dump

## Operation
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE: on start=1, latch first_addr into cur/raddr and last_addr into end; go to LOAD. A start in any other state is ignored and not queued.
- LOAD, one cycle: raddr=cur is stable. Capture out_data<=rdata, out_addr<=cur, out_last<=(cur==end), out_valid<=1. Go to SEND.
- SEND: out_valid, out_data, out_addr and out_last stay stable until out_valid&out_ready.
  - On handshake with out_last=1: out_valid<=0, go to DONE.
  - On handshake otherwise: out_valid<=0, cur<=cur+1 modulo 32 (31 wraps to 0), go to LOAD.
- DONE, one cycle: done=1, then IDLE.
- Word count N = ((last_addr - first_addr) mod 32) + 1.
  - first==last dumps exactly one word.
  - first>last wraps through 31->0, e.g. 30..1 gives 30,31,0,1.
  - A full 32-word dump needs last = first-1.
- Snapshot semantics: each word reflects the register-file contents in its LOAD cycle. Writes during SEND do not alter the beat already presented.
- Address 0 passes through whatever rdata returns, which is 0. There is no special-casing here.
- rst_n low at any time, including mid-dump:
  - immediately go to IDLE;
  - out_valid=0, out_last=0, busy=0, done=0;
  - raddr=0, out_addr=0, out_data=0.
  - The interrupted dump is abandoned and is not resumed.

## Timing
- Reset values: all outputs 0; FSM in IDLE.
- start sampled at edge E: LOAD during cycle E+1; out_valid rises at edge E+2.
- Throughput: at most one beat per 2 cycles. With out_ready held high, N words take 2N cycles from the first LOAD to the last handshake.
- done is asserted in the cycle after the last handshake. busy falls on the same edge that done falls.
- busy = (state != IDLE).
- out_ready low stalls indefinitely in SEND with no data change. out_ready is ignored while out_valid=0.
- raddr changes only on the edge entering LOAD, or on reset. It is held constant otherwise.

## Test plan
- Basic dump: preload reg k = 0x1000_0000+k; start, first=1, last=4, out_ready=1 -> 4 beats (1,0x10000001) .. (4,0x10000004), out_last only on addr 4. Beats are 2 cycles apart; done pulses 1 cycle after beat 4; busy low the cycle after done.
- Wrap and zero: first=30, last=1 -> addresses 30,31,0,1. The addr-0 beat has out_data=0. Exactly 4 beats.
- Single and full: first=last=7 -> one beat with out_last=1. Then first=5, last=4 -> 32 beats in order 5..31,0..4.
- Back-pressure: out_ready toggled randomly, including a 10-cycle low on beat 2 -> out_data, out_addr and out_last stay stable while stalled. No beat is lost or duplicated.
- Start while busy and snapshot: a second start mid-dump is ignored, with the beat count unchanged. A write to the register currently in SEND leaves out_data unchanged. The next dump returns the new value.
- Reset mid-dump: assert rst_n=0 during SEND of beat 3 -> out_valid, busy, done, raddr and out_* go to 0 asynchronously. After release, IDLE and a new start dumps correctly.
